// File: rtl/alu_rtl_core.sv
// alu_rtl_core: handshaked two-operand ALU.
// An opcode token selects add/sub and which operands are fresh; the result and
// its flags leave on two independent valid/ready channels.
module alu_rtl_core #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             OP_valid,
    input  logic [1:0]       OP_data,
    output logic             OP_ready,
    input  logic             A_valid,
    input  logic [WIDTH-1:0] A_data,
    output logic             A_ready,
    input  logic             B_valid,
    input  logic [WIDTH-1:0] B_data,
    output logic             B_ready,
    output logic             Y_valid,
    output logic [WIDTH-1:0] Y_data,
    input  logic             Y_ready,
    output logic             Z_valid,
    output logic [WIDTH-1:0] Z_data,
    input  logic             Z_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GET  = 2'd1,
        EXEC = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t           state_reg;
    logic [1:0]       opcode_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] y_data_reg;
    logic [3:0]       z_flags_reg;
    logic             y_valid_reg;
    logic             z_valid_reg;
    logic             op_ready_reg;
    logic             a_ready_reg;
    logic             b_ready_reg;

    // Arithmetic datapath results, consumed only in EXEC
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] y_next;
    logic [3:0]       flags_next;
    logic             is_sub;

    // Handshake bookkeeping for GET and SEND
    logic a_ready_next;
    logic b_ready_next;
    logic y_valid_next;
    logic z_valid_next;

    assign OP_ready = op_ready_reg;
    assign A_ready  = a_ready_reg;
    assign B_ready  = b_ready_reg;
    assign Y_valid  = y_valid_reg;
    assign Y_data   = y_data_reg;
    assign Z_valid  = z_valid_reg;

    // Flag word: four flag bits at the bottom, everything above tied low
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_z_data
            if (gi < 4) begin : g_flag
                assign Z_data[gi] = z_flags_reg[gi];
            end else begin : g_pad
                assign Z_data[gi] = 1'b0;
            end
        end
    endgenerate

    // Opcode bit 0 selects subtract; ops 10/11 differ from 00/01 only in which
    // operand register was refreshed, so the datapath is the same
    always_comb begin
        is_sub   = opcode_reg[0];
        add_full = {1'b0, a_reg} + {1'b0, b_reg};
        sub_res  = a_reg - b_reg;
        y_next   = is_sub ? sub_res : add_full[WIDTH-1:0];
        flags_next = 4'b0000;
        flags_next[0] = (y_next == '0);
        flags_next[1] = y_next[WIDTH-1];
        flags_next[2] = is_sub ? (a_reg < b_reg) : add_full[WIDTH];
        if (is_sub) begin
            flags_next[3] = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                            (y_next[WIDTH-1] != a_reg[WIDTH-1]);
        end else begin
            flags_next[3] = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                            (y_next[WIDTH-1] != a_reg[WIDTH-1]);
        end
    end

    // A ready flag stays up until its operand is taken; a valid flag stays up
    // until its result is taken
    always_comb begin
        a_ready_next = a_ready_reg && !A_valid;
        b_ready_next = b_ready_reg && !B_valid;
        y_valid_next = y_valid_reg && !Y_ready;
        z_valid_next = z_valid_reg && !Z_ready;
    end

    // Control FSM with registered ready/valid outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= IDLE;
            opcode_reg   <= 2'b00;
            a_reg        <= '0;
            b_reg        <= '0;
            y_data_reg   <= '0;
            z_flags_reg  <= 4'b0000;
            y_valid_reg  <= 1'b0;
            z_valid_reg  <= 1'b0;
            op_ready_reg <= 1'b0;
            a_ready_reg  <= 1'b0;
            b_ready_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (OP_valid && op_ready_reg) begin
                        opcode_reg   <= OP_data;
                        a_ready_reg  <= (OP_data != 2'b11);
                        b_ready_reg  <= (OP_data != 2'b10);
                        op_ready_reg <= 1'b0;
                        state_reg    <= GET;
                    end else begin
                        op_ready_reg <= 1'b1;
                    end
                end
                GET: begin
                    if (A_valid && a_ready_reg) begin
                        a_reg <= A_data;
                    end
                    if (B_valid && b_ready_reg) begin
                        b_reg <= B_data;
                    end
                    a_ready_reg <= a_ready_next;
                    b_ready_reg <= b_ready_next;
                    if (!a_ready_next && !b_ready_next) begin
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    y_data_reg  <= y_next;
                    z_flags_reg <= flags_next;
                    y_valid_reg <= 1'b1;
                    z_valid_reg <= 1'b1;
                    state_reg   <= SEND;
                end
                SEND: begin
                    y_valid_reg <= y_valid_next;
                    z_valid_reg <= z_valid_next;
                    if (!y_valid_next && !z_valid_next) begin
                        op_ready_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rtl_core.sv
// Directed bench for alu_rtl_core: hand-computed results and flags, operand
// ordering, output back-pressure and reset during an in-flight result.
module tb_alu_rtl_core;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        OP_valid;
    logic [1:0]  OP_data;
    logic        OP_ready;
    logic        A_valid;
    logic [15:0] A_data;
    logic        A_ready;
    logic        B_valid;
    logic [15:0] B_data;
    logic        B_ready;
    logic        Y_valid;
    logic [15:0] Y_data;
    logic        Y_ready;
    logic        Z_valid;
    logic [15:0] Z_data;
    logic        Z_ready;

    int vectors    = 0;
    int miscompares = 0;

    alu_rtl_core #(.WIDTH(16)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .OP_valid (OP_valid),
        .OP_data  (OP_data),
        .OP_ready (OP_ready),
        .A_valid  (A_valid),
        .A_data   (A_data),
        .A_ready  (A_ready),
        .B_valid  (B_valid),
        .B_data   (B_data),
        .B_ready  (B_ready),
        .Y_valid  (Y_valid),
        .Y_data   (Y_data),
        .Y_ready  (Y_ready),
        .Z_valid  (Z_valid),
        .Z_data   (Z_data),
        .Z_ready  (Z_ready)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present an opcode from a falling edge; returns on the falling edge after the transfer
    task automatic send_op(input logic [1:0] op);
        logic done;
        done     = 1'b0;
        OP_data  = op;
        OP_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            done = OP_ready;
            @(negedge CLK);
        end
        OP_valid = 1'b0;
        if (!done) chk("op_timeout", 32'd0, 32'd1);
    endtask

    // Offer the requested operands; A may be held back a_dly cycles
    task automatic send_ab(input logic use_a, input logic [15:0] a, input int a_dly,
                           input logic use_b, input logic [15:0] b,
                           output int a_iter, output int b_iter);
        logic a_done, b_done, ta, tb;
        a_done = !use_a;
        b_done = !use_b;
        a_iter = -1;
        b_iter = -1;
        for (int i = 0; i < 40 && !(a_done && b_done); i++) begin
            if (!a_done && i >= a_dly) begin A_valid = 1'b1; A_data = a; end
            if (!b_done) begin B_valid = 1'b1; B_data = b; end
            if (use_a && i < a_dly) chk("a_ready_waiting", {31'd0, A_ready}, 32'd1);
            ta = !a_done && A_valid && A_ready;
            tb = !b_done && B_valid && B_ready;
            @(negedge CLK);
            if (ta) begin A_valid = 1'b0; a_done = 1'b1; a_iter = i; end
            if (tb) begin B_valid = 1'b0; b_done = 1'b1; b_iter = i; end
        end
        if (!(a_done && b_done)) chk("operand_timeout", 32'd0, 32'd1);
    endtask

    // Wait on falling edges for the result to appear; lat counts the edges waited
    task automatic wait_result(output int lat);
        lat = 0;
        while (!Y_valid && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        chk("result_present", {31'd0, Y_valid}, 32'd1);
        chk("flag_present", {31'd0, Z_valid}, 32'd1);
    endtask

    // Full transaction with both result channels ready
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic use_a, input logic [15:0] a, input int a_dly,
                          input logic use_b, input logic [15:0] b,
                          input logic [15:0] ey, input logic [15:0] ez,
                          output int a_iter, output int b_iter);
        int lat;
        send_op(op);
        send_ab(use_a, a, a_dly, use_b, b, a_iter, b_iter);
        wait_result(lat);
        chk({tag, "_latency"}, lat, 32'd1);
        chk({tag, "_y"}, {16'd0, Y_data}, {16'd0, ey});
        chk({tag, "_z"}, {16'd0, Z_data}, {16'd0, ez});
        $display("txn %s op=%0d a=0x%04h b=0x%04h y=0x%04h z=0x%04h", tag, op, a, b, Y_data, Z_data);
        @(negedge CLK);
        chk({tag, "_y_drop"}, {31'd0, Y_valid}, 32'd0);
        chk({tag, "_z_drop"}, {31'd0, Z_valid}, 32'd0);
        chk({tag, "_op_ready"}, {31'd0, OP_ready}, 32'd1);
    endtask

    initial begin
        int ai, bi, lat;
        RESET    = 1'b1;
        OP_valid = 1'b0;
        OP_data  = 2'b00;
        A_valid  = 1'b0;
        A_data   = 16'h0000;
        B_valid  = 1'b0;
        B_data   = 16'h0000;
        Y_ready  = 1'b1;
        Z_ready  = 1'b1;

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_op_ready", {31'd0, OP_ready}, 32'd0);
        chk("rst_a_ready", {31'd0, A_ready}, 32'd0);
        chk("rst_b_ready", {31'd0, B_ready}, 32'd0);
        chk("rst_y_valid", {31'd0, Y_valid}, 32'd0);
        chk("rst_z_valid", {31'd0, Z_valid}, 32'd0);
        chk("rst_y_data", {16'd0, Y_data}, 32'd0);
        chk("rst_z_data", {16'd0, Z_data}, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("post_rst_op_ready", {31'd0, OP_ready}, 32'd1);

        // Basic add / sub
        run_op("add_5_7", 2'b00, 1'b1, 16'd5, 0, 1'b1, 16'd7, 16'd12, 16'h0000, ai, bi);
        run_op("sub_3_5", 2'b01, 1'b1, 16'd3, 0, 1'b1, 16'd5, 16'hFFFE, 16'h0006, ai, bi);
        run_op("add_ovf", 2'b00, 1'b1, 16'h8000, 0, 1'b1, 16'h8000, 16'h0000, 16'h000D, ai, bi);

        // A-only op with junk on the unrequested B channel
        B_valid = 1'b1;
        B_data  = 16'h1234;
        run_op("newa_add", 2'b10, 1'b1, 16'd1, 0, 1'b0, 16'd0, 16'h8001, 16'h0002, ai, bi);
        chk("b_not_consumed", {31'd0, B_ready}, 32'd0);
        B_valid = 1'b0;

        // B-only op with junk on the unrequested A channel
        A_valid = 1'b1;
        A_data  = 16'h7777;
        run_op("newb_sub", 2'b11, 1'b0, 16'd0, 0, 1'b1, 16'd1, 16'h0000, 16'h0001, ai, bi);
        chk("a_not_consumed", {31'd0, A_ready}, 32'd0);
        A_valid = 1'b0;

        // B offered three cycles before A
        run_op("b_first", 2'b00, 1'b1, 16'h0100, 3, 1'b1, 16'h0023, 16'h0123, 16'h0000, ai, bi);
        chk("b_first_b_iter", bi, 32'd0);
        chk("b_first_a_iter", ai, 32'd3);

        // Result channel stalled for ten cycles, flag channel free
        Y_ready = 1'b0;
        send_op(2'b01);
        send_ab(1'b1, 16'd10, 0, 1'b1, 16'd3, ai, bi);
        wait_result(lat);
        chk("stall_y", {16'd0, Y_data}, 32'd7);
        chk("stall_z", {16'd0, Z_data}, 32'd0);
        $display("txn stall op=1 a=0x000a b=0x0003 y=0x%04h z=0x%04h", Y_data, Z_data);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("stall_y_valid", {31'd0, Y_valid}, 32'd1);
            chk("stall_y_hold", {16'd0, Y_data}, 32'd7);
            chk("stall_z_once", {31'd0, Z_valid}, 32'd0);
            chk("stall_op_ready", {31'd0, OP_ready}, 32'd0);
        end
        Y_ready = 1'b1;
        @(negedge CLK);
        chk("stall_y_done", {31'd0, Y_valid}, 32'd0);
        chk("stall_idle", {31'd0, OP_ready}, 32'd1);

        // Reset while the result is waiting in SEND
        Y_ready = 1'b0;
        Z_ready = 1'b0;
        send_op(2'b00);
        send_ab(1'b1, 16'h1111, 0, 1'b1, 16'h2222, ai, bi);
        wait_result(lat);
        chk("pre_rst_y", {16'd0, Y_data}, 32'h3333);
        RESET = 1'b1;
        @(negedge CLK);
        chk("mid_rst_y_valid", {31'd0, Y_valid}, 32'd0);
        chk("mid_rst_z_valid", {31'd0, Z_valid}, 32'd0);
        chk("mid_rst_y_data", {16'd0, Y_data}, 32'd0);
        chk("mid_rst_z_data", {16'd0, Z_data}, 32'd0);
        chk("mid_rst_op_ready", {31'd0, OP_ready}, 32'd0);
        RESET   = 1'b0;
        Y_ready = 1'b1;
        Z_ready = 1'b1;
        @(negedge CLK);
        chk("after_rst_op_ready", {31'd0, OP_ready}, 32'd1);
        run_op("rst_newa", 2'b10, 1'b1, 16'd4, 0, 1'b0, 16'd0, 16'h0004, 16'h0000, ai, bi);

        // Breg now 0, Areg now 4: 4 - 5 borrows, goes negative
        run_op("newb_neg", 2'b11, 1'b0, 16'd0, 0, 1'b1, 16'd5, 16'hFFFF, 16'h0006, ai, bi);

        // Signed overflow on subtract: 0x8000 - 1
        run_op("sub_ovf", 2'b01, 1'b1, 16'h8000, 0, 1'b1, 16'h0001, 16'h7FFF, 16'h0008, ai, bi);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
